// File: rtl/ss_arbiter_pkg.sv
// ss_arbiter_pkg: shared FSM state, channel index type and default timing constants
package ss_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, GAP} state_t;
    typedef enum logic {CH1, CH2} chan_t;
    localparam int DEF_SLOT_CYCLES  = 1000;
    localparam int DEF_GUARD_CYCLES = 2;
    localparam int DEF_DEB_CYCLES   = 16;
endpackage

// File: rtl/ss_arbiter_sync_debounce.sv
// sync_debounce: 2-flop synchronizer plus debounce counter for one bouncing input
// Ports: clk, rst (async, active-high); raw = asynchronous bouncing level; db = registered debounced level
module sync_debounce import ss_arbiter_pkg::*; #(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          done;
    // a 1-bit level that changes while differing from db must return to db, so one equality test covers both clear cases
    assign done = sync[1] != db && cnt == CW'(DEB_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            cnt  <= (sync[1] == db || done) ? '0 : cnt + 1'b1;
            db   <= done ? sync[1] : db;
        end
    end
endmodule

// File: rtl/ss_arbiter.sv
// ss_arbiter: round-robin grant of two tristate enables with guard gaps, slot limit and DIP debouncing
// Ports: clk, rst (async, active-high); miso1_in/miso2_in = async channel requests;
//        dip1/dip2 = raw DIP switches; ss1/ss2 = registered enables; dip1_db/dip2_db = debounced DIPs;
//        busy = FSM not idle
module ss_arbiter import ss_arbiter_pkg::*; #(
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic miso1_in,
    input  logic miso2_in,
    input  logic dip1,
    input  logic dip2,
    output logic ss1,
    output logic ss2,
    output logic dip1_db,
    output logic dip2_db,
    output logic busy
);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int SW = $clog2(SLOT_CYCLES + 1);
    logic [1:0]    req1_sync, req2_sync;
    logic          req1, req2, tgt_req;
    state_t        state, state_n;
    chan_t         tgt, tgt_n, last, last_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [SW-1:0] scnt, scnt_n;
    assign req1    = req1_sync[1];
    assign req2    = req2_sync[1];
    assign tgt_req = tgt == CH1 ? req1 : req2;
    assign busy    = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req1_sync <= '0;
            req2_sync <= '0;
            state     <= IDLE;
            tgt       <= CH1;
            last      <= CH2;
            gcnt      <= '0;
            scnt      <= '0;
            ss1       <= 1'b0;
            ss2       <= 1'b0;
        end else begin
            req1_sync <= {req1_sync[0], miso1_in};
            req2_sync <= {req2_sync[0], miso2_in};
            state     <= state_n;
            tgt       <= tgt_n;
            last      <= last_n;
            gcnt      <= gcnt_n;
            scnt      <= scnt_n;
            // enables follow the next state so they rise and fall on the same edge as ACTIVE is entered or left
            ss1       <= state_n == ACTIVE && tgt_n == CH1;
            ss2       <= state_n == ACTIVE && tgt_n == CH2;
        end
    end
    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        last_n  = last;
        gcnt_n  = gcnt;
        scnt_n  = scnt;
        case (state)
            IDLE: if (req1 || req2) begin
                tgt_n   = req1 && req2 ? (last == CH1 ? CH2 : CH1) : (req1 ? CH1 : CH2);
                state_n = SETUP;
                gcnt_n  = '0;
            end
            SETUP: if (!tgt_req) begin
                state_n = GAP;
                gcnt_n  = '0;
            end else if (gcnt == GW'(GUARD_CYCLES - 1)) begin
                state_n = ACTIVE;
                last_n  = tgt;
                scnt_n  = '0;
            end else begin
                gcnt_n = gcnt + 1'b1;
            end
            ACTIVE: if (!tgt_req || scnt == SW'(SLOT_CYCLES - 1)) begin
                state_n = GAP;
                gcnt_n  = '0;
            end else begin
                scnt_n = scnt + 1'b1;
            end
            default: if (gcnt == GW'(GUARD_CYCLES - 1)) begin
                state_n = IDLE;
            end else begin
                gcnt_n = gcnt + 1'b1;
            end
        endcase
    end
    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dip1 (.clk(clk), .rst(rst), .raw(dip1), .db(dip1_db));
    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dip2 (.clk(clk), .rst(rst), .raw(dip2), .db(dip2_db));
endmodule

// File: tb/tb_ss_arbiter.sv
// tb_ss_arbiter: directed and randomized checks of ss_arbiter against a behavioural model
module tb_ss_arbiter;
    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int DEB   = 4;
    logic clk = 1'b0;
    logic rst, miso1_in, miso2_in, dip1, dip2;
    logic ss1, ss2, dip1_db, dip2_db, busy;
    int checks = 0;
    int failures = 0;
    int n, nb, hm, hd;
    ss_arbiter #(.SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .miso1_in(miso1_in), .miso2_in(miso2_in),
        .dip1(dip1), .dip2(dip2), .ss1(ss1), .ss2(ss2),
        .dip1_db(dip1_db), .dip2_db(dip2_db), .busy(busy)
    );
    always #5 clk = ~clk;
    // model: phase 0 idle, 1 setup, 2 active, 3 gap; left = clocks remaining in the phase
    bit a1, a2, r1, r2, ea1, ea2, ds1, ds2, m_ss1, m_ss2, m_db1, m_db2;
    int phase, left, tgt, last;
    bit h1[$];
    bit h2[$];
    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endfunction
    function automatic void model_reset();
        {a1, a2, r1, r2, ea1, ea2, ds1, ds2, m_ss1, m_ss2, m_db1, m_db2} = '0;
        phase = 0;
        left  = 0;
        tgt   = 1;
        last  = 2;
        h1.delete();
        h2.delete();
    endfunction
    // debounced level flips once the last DEB synchronized samples all disagree with it
    function automatic int disagree(bit q[$], bit v);
        int c = 0;
        foreach (q[i]) if (q[i] != v) c++;
        return c;
    endfunction
    function automatic void model_edge();
        bit treq;
        treq = (tgt == 1) ? r1 : r2;
        case (phase)
            0: if (r1 || r2) begin
                tgt   = (r1 && r2) ? 3 - last : (r1 ? 1 : 2);
                phase = 1;
                left  = GUARD;
            end
            1: if (!treq) begin
                phase = 3;
                left  = GUARD;
            end else begin
                left--;
                if (left == 0) begin
                    phase = 2;
                    left  = SLOT;
                    last  = tgt;
                end
            end
            2: begin
                left--;
                if (!treq || left == 0) begin
                    phase = 3;
                    left  = GUARD;
                end
            end
            default: begin
                left--;
                if (left == 0) phase = 0;
            end
        endcase
        m_ss1 = phase == 2 && tgt == 1;
        m_ss2 = phase == 2 && tgt == 2;
        h1.push_back(ds1);
        h2.push_back(ds2);
        if (h1.size() > DEB) void'(h1.pop_front());
        if (h2.size() > DEB) void'(h2.pop_front());
        if (disagree(h1, m_db1) == DEB) m_db1 = ds1;
        if (disagree(h2, m_db2) == DEB) m_db2 = ds2;
        r1 = a1; a1 = miso1_in;
        r2 = a2; a2 = miso2_in;
        ds1 = ea1; ea1 = dip1;
        ds2 = ea2; ea2 = dip2;
    endfunction
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        chk("ss1", ss1, m_ss1);
        chk("ss2", ss2, m_ss2);
        chk("busy", busy, phase != 0);
        chk("dip1_db", dip1_db, m_db1);
        chk("dip2_db", dip2_db, m_db2);
        chk("exclusive", ss1 & ss2, 0);
    endtask
    task automatic wait_idle();
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        {miso1_in, miso2_in, dip1, dip2} = '0;
        model_reset();
        repeat (3) step();
        chk("rst_ss1", ss1, 0);
        chk("rst_ss2", ss2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_db", {dip1_db, dip2_db}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        // single held request: latency, slot length, re-grant
        @(negedge clk);
        miso1_in = 1'b1;
        n = 0;
        while (!ss1 && n < 50) begin step(); n++; end
        chk("grant_latency", n, 2 + 1 + GUARD);
        n = 0;
        while (ss1 && n < 50) begin step(); n++; end
        chk("slot_length", n, SLOT);
        n = 0;
        while (!ss1 && n < 50) begin step(); n++; end
        chk("regrant_delay", n, GUARD + 1 + GUARD);
        @(negedge clk);
        miso1_in = 1'b0;
        step();
        wait_idle();
        // simultaneous requests alternate starting with channel 1 after reset
        do_reset();
        @(negedge clk);
        miso1_in = 1'b1;
        miso2_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!(ss1 || ss2) && n < 50) begin step(); n++; end
            chk("rr_ss1", ss1, k != 1);
            chk("rr_ss2", ss2, k == 1);
            n = 0;
            while ((ss1 || ss2) && n < 50) begin step(); n++; end
            chk("rr_length", n, SLOT);
        end
        @(negedge clk);
        {miso1_in, miso2_in} = '0;
        step();
        wait_idle();
        // one-clock request pulse aborts in SETUP
        @(negedge clk);
        miso2_in = 1'b1;
        step();
        @(negedge clk);
        miso2_in = 1'b0;
        nb = 0;
        repeat (8) begin
            step();
            if (busy) nb++;
            chk("abort_ss2", ss2, 0);
        end
        chk("abort_busy_clocks", nb, 1 + GUARD);
        // bouncing DIP never passes, a stable level passes after sync + DEB
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dip1 = ~dip1;
            repeat (2) begin
                step();
                chk("bounce_db", dip1_db, 0);
            end
        end
        @(negedge clk);
        dip1 = 1'b1;
        n = 0;
        while (!dip1_db && n < 50) begin step(); n++; end
        chk("debounce_latency", n, 2 + DEB);
        // reset in ACTIVE drops the enable without a clock edge
        @(negedge clk);
        miso1_in = 1'b1;
        n = 0;
        while (!ss1 && n < 50) begin step(); n++; end
        repeat (3) step();
        chk("active_before_rst", ss1, 1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_ss1", ss1, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_db", dip1_db, 0);
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!ss1 && n < 50) begin step(); n++; end
        chk("post_rst_latency", n, 2 + 1 + GUARD);
        @(negedge clk);
        miso1_in = 1'b0;
        step();
        wait_idle();
        // randomized traffic
        hm = 0;
        hd = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (hm == 0) begin
                miso1_in = $urandom_range(0, 9) < 6;
                miso2_in = $urandom_range(0, 9) < 6;
                hm = $urandom_range(1, 25);
            end
            hm--;
            if (hd == 0) begin
                dip1 = 1'($urandom_range(0, 1));
                dip2 = 1'($urandom_range(0, 1));
                hd = $urandom_range(1, 8);
            end
            hd--;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ss_arbiter.md
SS_ARBITER -- requirements
Module: ss_arbiter

Interface
REQ-001 Parameter SLOT_CYCLES, default 1000: maximum clocks an enable stays high per grant (legal range 1..65535).
REQ-002 Parameter GUARD_CYCLES, default 2: clocks with both enables low before any grant and after any release (legal range 1..255).
REQ-003 Parameter DEB_CYCLES, default 16: clocks a synchronized DIP level must be stable before the debounced output follows it (legal range 1..65535).
REQ-004 clk  in  1  single clock for all state.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 miso1_in  in  1  channel-1 request, asynchronous to clk.
REQ-007 miso2_in  in  1  channel-2 request, asynchronous to clk.
REQ-008 dip1  in  1  raw DIP switch 1, asynchronous and bouncing.
REQ-009 dip2  in  1  raw DIP switch 2, asynchronous and bouncing.
REQ-010 ss1  out  1  tristate enable for channel 1 (registered).
REQ-011 ss2  out  1  tristate enable for channel 2 (registered).
REQ-012 dip1_db  out  1  debounced dip1 (registered), feeds the channel-1 data inverter.
REQ-013 dip2_db  out  1  debounced dip2 (registered), feeds the channel-2 data inverter.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Each of miso1_in, miso2_in, dip1, dip2 SHALL pass through a 2-flop synchronizer; all decisions use synchronized values (req1, req2, dip1_s, dip2_s).
REQ-016 FSM states SHALL be IDLE, SETUP, ACTIVE, GAP.
REQ-017 IDLE: a single high request SHALL latch that channel as target and enter SETUP at the next edge.
REQ-018 IDLE with req1 and req2 both high SHALL target the channel not served last; the last-served pointer resets to channel 2, so channel 1 wins the first tie.
REQ-019 SETUP SHALL last exactly GUARD_CYCLES clocks with ss1=ss2=0, then enter ACTIVE.
REQ-020 A target request dropping during SETUP SHALL abort to GAP without asserting any enable.
REQ-021 On entering ACTIVE, the target enable SHALL rise, the last-served pointer SHALL update, and the slot counter SHALL clear.
REQ-022 ACTIVE SHALL exit to GAP when the target request drops (enable low at the next edge) or after SLOT_CYCLES clocks high, whichever comes first.
REQ-023 GAP SHALL last exactly GUARD_CYCLES clocks with both enables low, then return to IDLE; requests arriving during GAP wait.
REQ-024 ss1 and ss2 SHALL never be high in the same cycle.
REQ-025 A request held high continuously SHALL be re-granted after GAP, subject to round-robin if the other request is also high.
REQ-026 Latency: a synchronized request seen in IDLE at edge t SHALL produce the enable high after edge t+1+GUARD_CYCLES.
REQ-027 Debounce per channel: a counter SHALL clear whenever dip_s equals dip_db or changes value, and dip_db SHALL take dip_s after DEB_CYCLES consecutive stable differing clocks.
REQ-028 Counters SHALL saturate, never wrap, and be sized to clog2(max parameter + 1) bits.

Reset
REQ-029 While rst is high: state=IDLE, ss1=ss2=0, busy=0, dip1_db=dip2_db=0, all synchronizers and counters 0, pointer=channel 2.
REQ-030 Reset asserted mid-ACTIVE SHALL drop the enables asynchronously without waiting for a clock edge.
REQ-031 After rst releases, the first grant SHALL still honour the full SETUP guard.

Structure
REQ-032 Package ss_arbiter_pkg SHALL hold the state enum, the channel-index type and the default parameter constants.
REQ-033 Sub-module sync_debounce (2-flop synchronizer plus debounce counter, parameter DEB_CYCLES) SHALL be instantiated once per DIP channel; the request synchronizers stay inline.

Verification (SLOT_CYCLES=8, GUARD_CYCLES=2, DEB_CYCLES=4)
REQ-034 Raise miso1_in and hold it -> ss1 high after 2 (sync) + 1 + 2 clocks, stays high for exactly 8 clocks, 2 low clocks of GAP, then the grant repeats.
REQ-035 Raise miso1_in and miso2_in on the same edge and hold both -> grants alternate ch1, ch2, ch1 with 8 clocks each and ss1 & ss2 never high together.
REQ-036 Pulse miso2_in for 1 clock (synchronized) during IDLE -> SETUP entered, grant aborted, ss2 never high, FSM back in IDLE after 2 GAP clocks.
REQ-037 Toggle dip1 every 2 clocks for 20 clocks, then hold it at 1 -> dip1_db stays 0 during the toggling and becomes 1 exactly 2 + 4 clocks after the final change.
REQ-038 Assert rst 3 clocks into ACTIVE -> ss1 goes low before the next edge; after release, a held request is regranted only after the full 2-clock SETUP.
